// File: rtl/ex_stage_if.sv
// ID/EX-side inputs and EX/MEM-side outputs of the execute stage, grouped as one bundle.
// master = pipeline / bench side, slave = ex_stage_unit.
interface ex_stage_if #(
    parameter int DATA_W = 32
);
    logic              flush;
    logic              in_valid;
    logic [4:0]        in_instr_bits_15_11;
    logic [4:0]        in_instr_bits_20_16;
    logic [DATA_W-1:0] in_extended_bits;
    logic [DATA_W-1:0] in_read_data1;
    logic [DATA_W-1:0] in_read_data2;
    logic [DATA_W-1:0] in_new_pc_value;
    logic              in_RegDst;
    logic              in_RegWrite;
    logic              in_ALUSrc;
    logic              in_MemWrite;
    logic              in_MemRead;
    logic              in_MemToReg;
    logic              in_PCSrc;
    logic [2:0]        in_ALUOp;

    logic              stall;
    logic              out_valid;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] store_data;
    logic [4:0]        write_reg;
    logic [DATA_W-1:0] branch_target;
    logic              branch_taken;
    logic              RegWrite;
    logic              MemWrite;
    logic              MemRead;
    logic              MemToReg;

    modport master (
        output flush, in_valid, in_instr_bits_15_11, in_instr_bits_20_16,
               in_extended_bits, in_read_data1, in_read_data2, in_new_pc_value,
               in_RegDst, in_RegWrite, in_ALUSrc, in_MemWrite, in_MemRead,
               in_MemToReg, in_PCSrc, in_ALUOp,
        input  stall, out_valid, alu_result, store_data, write_reg,
               branch_target, branch_taken, RegWrite, MemWrite, MemRead, MemToReg
    );

    modport slave (
        input  flush, in_valid, in_instr_bits_15_11, in_instr_bits_20_16,
               in_extended_bits, in_read_data1, in_read_data2, in_new_pc_value,
               in_RegDst, in_RegWrite, in_ALUSrc, in_MemWrite, in_MemRead,
               in_MemToReg, in_PCSrc, in_ALUOp,
        output stall, out_valid, alu_result, store_data, write_reg,
               branch_target, branch_taken, RegWrite, MemWrite, MemRead, MemToReg
    );
endinterface

// File: rtl/ex_stage_unit.sv
// Execute stage: single-cycle ALU/branch evaluation registered into EX/MEM, plus an
// iterative shift-add multiply that stalls the front end for DATA_W cycles.
//
//   state  | meaning
//   S_IDLE | accepting ID/EX work; single-cycle ops complete at the next edge
//   S_MUL  | one shift-add step per cycle; result issued on the step with cnt = DATA_W-1
module ex_stage_unit #(
    parameter int         DATA_W    = 32,
    parameter logic [2:0] ALUOP_MUL = 3'b101
) (
    input  logic      clk,
    input  logic      rst,
    ex_stage_if.slave ex
);
    localparam int               CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] mcand;
    logic [DATA_W-1:0] mplier;
    logic [DATA_W-1:0] acc;
    logic [4:0]        mul_wr;
    logic              mul_regwrite;
    logic              mul_memwrite;
    logic              mul_memread;
    logic              mul_memtoreg;

    logic [DATA_W-1:0] opnd_b;
    logic [DATA_W-1:0] alu_c;
    logic [DATA_W-1:0] acc_step;
    logic [DATA_W-1:0] target_c;
    logic [4:0]        wr_c;
    logic              taken_c;
    logic              is_mul;
    logic              final_step;

    always_comb begin
        opnd_b     = ex.in_ALUSrc ? ex.in_extended_bits : ex.in_read_data2;
        wr_c       = ex.in_RegDst ? ex.in_instr_bits_15_11 : ex.in_instr_bits_20_16;
        taken_c    = ex.in_PCSrc && (ex.in_read_data1 == ex.in_read_data2);
        target_c   = ex.in_new_pc_value + (ex.in_extended_bits << 2);
        is_mul     = (ex.in_ALUOp == ALUOP_MUL);
        final_step = (cnt == CNT_LAST);
        acc_step   = mplier[0] ? acc + mcand : acc;
        case (ex.in_ALUOp)
            3'b000:  alu_c = ex.in_read_data1 + opnd_b;
            3'b001:  alu_c = ex.in_read_data1 - opnd_b;
            3'b010:  alu_c = ex.in_read_data1 & opnd_b;
            3'b011:  alu_c = ex.in_read_data1 | opnd_b;
            3'b100:  alu_c = {{(DATA_W-1){1'b0}}, ($signed(ex.in_read_data1) < $signed(opnd_b))};
            3'b110:  alu_c = ~(ex.in_read_data1 | opnd_b);
            3'b111:  alu_c = opnd_b;
            default: alu_c = '0;
        endcase
    end

    // Final multiply cycle drops stall so ID/EX advances on the same edge the result issues.
    assign ex.stall = !rst && !ex.flush &&
                      ((state == S_IDLE && ex.in_valid && is_mul) ||
                       (state == S_MUL && !final_step));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= S_IDLE;
            cnt              <= '0;
            mcand            <= '0;
            mplier           <= '0;
            acc              <= '0;
            mul_wr           <= '0;
            mul_regwrite     <= 1'b0;
            mul_memwrite     <= 1'b0;
            mul_memread      <= 1'b0;
            mul_memtoreg     <= 1'b0;
            ex.out_valid     <= 1'b0;
            ex.alu_result    <= '0;
            ex.store_data    <= '0;
            ex.write_reg     <= '0;
            ex.branch_target <= '0;
            ex.branch_taken  <= 1'b0;
            ex.RegWrite      <= 1'b0;
            ex.MemWrite      <= 1'b0;
            ex.MemRead       <= 1'b0;
            ex.MemToReg      <= 1'b0;
        end else begin
            // Bubble by default; data outputs hold.
            ex.out_valid    <= 1'b0;
            ex.branch_taken <= 1'b0;
            ex.RegWrite     <= 1'b0;
            ex.MemWrite     <= 1'b0;
            ex.MemRead      <= 1'b0;
            ex.MemToReg     <= 1'b0;
            if (ex.flush) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (ex.in_valid && is_mul) begin
                            mcand        <= ex.in_read_data1;
                            mplier       <= opnd_b;
                            acc          <= '0;
                            cnt          <= '0;
                            mul_wr       <= wr_c;
                            mul_regwrite <= ex.in_RegWrite;
                            mul_memwrite <= ex.in_MemWrite;
                            mul_memread  <= ex.in_MemRead;
                            mul_memtoreg <= ex.in_MemToReg;
                            state        <= S_MUL;
                        end else if (ex.in_valid) begin
                            ex.out_valid     <= 1'b1;
                            ex.alu_result    <= alu_c;
                            ex.store_data    <= ex.in_read_data2;
                            ex.write_reg     <= wr_c;
                            ex.branch_target <= target_c;
                            ex.branch_taken  <= taken_c;
                            ex.RegWrite      <= ex.in_RegWrite;
                            ex.MemWrite      <= ex.in_MemWrite;
                            ex.MemRead       <= ex.in_MemRead;
                            ex.MemToReg      <= ex.in_MemToReg;
                        end
                    end
                    S_MUL: begin
                        acc    <= acc_step;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt + 1'b1;
                        if (final_step) begin
                            ex.out_valid  <= 1'b1;
                            ex.alu_result <= acc_step;
                            ex.write_reg  <= mul_wr;
                            ex.RegWrite   <= mul_regwrite;
                            ex.MemWrite   <= mul_memwrite;
                            ex.MemRead    <= mul_memread;
                            ex.MemToReg   <= mul_memtoreg;
                            state         <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule
